id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus execute-stage operand selection, directly upstream of the ALU.

---
 rtl/id_ex_operand_stage.sv | 146 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register plus execute-stage operand selection.
// Holds the decoded instruction for one cycle, applies hazard-unit forwarding
// to form the ALU operands and store data, and resolves the branch target and
// taken decision from the ALU zero flag.
module id_ex_operand_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallE,
  input  logic               FlushE,
  input  logic [XLEN-1:0]    RD1D,
  input  logic [XLEN-1:0]    RD2D,
  input  logic [XLEN-1:0]    PCD,
  input  logic [XLEN-1:0]    PCPlus4D,
  input  logic [XLEN-1:0]    ImmExtD,
  input  logic [RADDR_W-1:0] Rs1D,
  input  logic [RADDR_W-1:0] Rs2D,
  input  logic [RADDR_W-1:0] RdD,
  input  logic               RegWriteD,
  input  logic               MemWriteD,
  input  logic               JumpD,
  input  logic               BranchD,
  input  logic               ALUSrcD,
  input  logic [1:0]         ResultSrcD,
  input  logic [2:0]         ALUControlD,
  input  logic [1:0]         ForwardAE,
  input  logic [1:0]         ForwardBE,
  input  logic [XLEN-1:0]    ALUResultM,
  input  logic [XLEN-1:0]    ResultW,
  input  logic               ZeroE,
  output logic [XLEN-1:0]    SrcAE,
  output logic [XLEN-1:0]    SrcBE,
  output logic [XLEN-1:0]    WriteDataE,
  output logic [2:0]         ALUControlE,
  output logic [XLEN-1:0]    PCTargetE,
  output logic               PCSrcE,
  output logic [XLEN-1:0]    PCPlus4E,
  output logic [RADDR_W-1:0] Rs1E,
  output logic [RADDR_W-1:0] Rs2E,
  output logic [RADDR_W-1:0] RdE,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic [1:0]         ResultSrcE,
  output logic               ValidE
);

  // All execute-stage state lives in one record so that flush/stall/load act
  // on every field uniformly; an all-zero record is the bubble.
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_write;
    logic               jump;
    logic               branch;
    logic               alu_src;
    logic [1:0]         result_src;
    logic [2:0]         alu_control;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    imm_ext;
  } ex_regs_t;

  ex_regs_t ex_d, ex_q;

  logic [XLEN-1:0] fwd_a, fwd_b;

  // Forward select: 01 writeback, 10 memory, 00/11 the registered read data.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] reg_val,
    input logic [XLEN-1:0] res_w,
    input logic [XLEN-1:0] alu_m
  );
    logic [XLEN-1:0] r;
    case (sel)
      2'b01:   r = res_w;
      2'b10:   r = alu_m;
      default: r = reg_val;
    endcase
    return r;
  endfunction

  // Next-state: flush beats stall beats load; a flush with stall still bubbles.
  always_comb begin
    ex_d = ex_q;
    if (FlushE) begin
      ex_d = '0;
    end else if (!StallE) begin
      ex_d.valid       = 1'b1;
      ex_d.reg_write   = RegWriteD;
      ex_d.mem_write   = MemWriteD;
      ex_d.jump        = JumpD;
      ex_d.branch      = BranchD;
      ex_d.alu_src     = ALUSrcD;
      ex_d.result_src  = ResultSrcD;
      ex_d.alu_control = ALUControlD;
      ex_d.rs1         = Rs1D;
      ex_d.rs2         = Rs2D;
      ex_d.rd          = RdD;
      ex_d.rd1         = RD1D;
      ex_d.rd2         = RD2D;
      ex_d.pc          = PCD;
      ex_d.pc_plus4    = PCPlus4D;
      ex_d.imm_ext     = ImmExtD;
    end
  end

  // Stage register; synchronous reset clears to the bubble, even mid-stall.
  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  // Operand forwarding and immediate select feeding the ALU.
  always_comb begin
    fwd_a = fwd_pick(ForwardAE, ex_q.rd1, ResultW, ALUResultM);
    fwd_b = fwd_pick(ForwardBE, ex_q.rd2, ResultW, ALUResultM);
  end

  assign SrcAE      = fwd_a;
  assign WriteDataE = fwd_b;
  assign SrcBE      = ex_q.alu_src ? ex_q.imm_ext : fwd_b;

  // Branch target wraps modulo 2^XLEN; ZeroE only reaches PCSrcE, never the
  // operands, so this combinational path cannot loop through the ALU.
  assign PCTargetE  = ex_q.pc + ex_q.imm_ext;
  assign PCSrcE     = ex_q.jump | (ex_q.branch & ZeroE);

  assign ALUControlE = ex_q.alu_control;
  assign PCPlus4E    = ex_q.pc_plus4;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;
  assign RegWriteE   = ex_q.reg_write;
  assign MemWriteE   = ex_q.mem_write;
  assign ResultSrcE  = ex_q.result_src;
  assign ValidE      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: the driver advances a reference
// model at each edge and queues the expected outputs; the monitor pops and
// compares on the falling edge.
module tb_id_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, StallE, FlushE;
  logic [XLEN-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [RW-1:0]   Rs1D, Rs2D, RdD;
  logic            RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]      ResultSrcD;
  logic [2:0]      ALUControlD;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [XLEN-1:0] ALUResultM, ResultW;
  logic            ZeroE;
  logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE, PCTargetE, PCPlus4E;
  logic [2:0]      ALUControlE;
  logic            PCSrcE;
  logic [RW-1:0]   Rs1E, Rs2E, RdE;
  logic            RegWriteE, MemWriteE, ValidE;
  logic [1:0]      ResultSrcE;

  id_ex_operand_stage #(.XLEN(XLEN), .RADDR_W(RW)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .ZeroE(ZeroE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE), .ALUControlE(ALUControlE),
    .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .ValidE(ValidE)
  );

  typedef struct {
    logic [XLEN-1:0] src_a, src_b, wdata, target, pc4;
    logic [2:0]      aluc;
    logic            pcsrc, rw, mw, valid;
    logic [RW-1:0]   rs1, rs2, rd;
    logic [1:0]      ressrc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: the instruction currently held in Execute, as plain fields.
  logic            m_valid, m_rw, m_mw, m_j, m_b, m_as;
  logic [1:0]      m_rsrc;
  logic [2:0]      m_aluc;
  logic [RW-1:0]   m_rs1, m_rs2, m_rd;
  logic [XLEN-1:0] m_rd1, m_rd2, m_pc, m_pc4, m_imm;

  task automatic model_edge();
    if (reset || FlushE) begin
      {m_valid, m_rw, m_mw, m_j, m_b, m_as} = '0;
      m_rsrc = '0; m_aluc = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
      m_rd1 = '0; m_rd2 = '0; m_pc = '0; m_pc4 = '0; m_imm = '0;
    end else if (!StallE) begin
      m_valid = 1'b1; m_rw = RegWriteD; m_mw = MemWriteD; m_j = JumpD;
      m_b = BranchD; m_as = ALUSrcD; m_rsrc = ResultSrcD; m_aluc = ALUControlD;
      m_rs1 = Rs1D; m_rs2 = Rs2D; m_rd = RdD;
      m_rd1 = RD1D; m_rd2 = RD2D; m_pc = PCD; m_pc4 = PCPlus4D; m_imm = ImmExtD;
    end
  endtask

  function automatic logic [XLEN-1:0] pick(input logic [1:0] sel, input logic [XLEN-1:0] own);
    logic [XLEN-1:0] srcs[4];
    srcs[0] = own; srcs[1] = ResultW; srcs[2] = ALUResultM; srcs[3] = own;
    return srcs[sel];
  endfunction

  task automatic push_expect();
    exp_t e;
    longint unsigned sum;
    e.src_a  = pick(ForwardAE, m_rd1);
    e.wdata  = pick(ForwardBE, m_rd2);
    e.src_b  = m_as ? m_imm : e.wdata;
    sum      = longint'(m_pc) + longint'(m_imm);
    e.target = XLEN'(sum % (64'd1 << XLEN));
    e.pcsrc  = m_j || (m_b && ZeroE);
    e.pc4 = m_pc4; e.aluc = m_aluc; e.rw = m_rw; e.mw = m_mw; e.valid = m_valid;
    e.rs1 = m_rs1; e.rs2 = m_rs2; e.rd = m_rd; e.ressrc = m_rsrc;
    exp_q.push_back(e);
  endtask

  // One cycle: edge -> model update -> expectation queued; inputs may change
  // only after the monitor has sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    push_expect();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, vectors, act, exp);
    end
  endtask

  // Monitor: the stage presents a result every cycle, so compare on each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      chk("SrcAE", SrcAE, e.src_a);
      chk("SrcBE", SrcBE, e.src_b);
      chk("WriteDataE", WriteDataE, e.wdata);
      chk("PCTargetE", PCTargetE, e.target);
      chk("PCSrcE", XLEN'(PCSrcE), XLEN'(e.pcsrc));
      chk("PCPlus4E", PCPlus4E, e.pc4);
      chk("ALUControlE", XLEN'(ALUControlE), XLEN'(e.aluc));
      chk("Rs1E", XLEN'(Rs1E), XLEN'(e.rs1));
      chk("Rs2E", XLEN'(Rs2E), XLEN'(e.rs2));
      chk("RdE", XLEN'(RdE), XLEN'(e.rd));
      chk("RegWriteE", XLEN'(RegWriteE), XLEN'(e.rw));
      chk("MemWriteE", XLEN'(MemWriteE), XLEN'(e.mw));
      chk("ResultSrcE", XLEN'(ResultSrcE), XLEN'(e.ressrc));
      chk("ValidE", XLEN'(ValidE), XLEN'(e.valid));
    end
  end

  task automatic clear_inputs();
    reset = 0; StallE = 0; FlushE = 0;
    RD1D = 0; RD2D = 0; PCD = 0; PCPlus4D = 0; ImmExtD = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0;
    RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
    ResultSrcD = 0; ALUControlD = 0; ForwardAE = 0; ForwardBE = 0;
    ALUResultM = 0; ResultW = 0; ZeroE = 0;
  endtask

  task automatic randomize_d();
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom;
    ImmExtD = $urandom; Rs1D = RW'($urandom); Rs2D = RW'($urandom); RdD = RW'($urandom);
    RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); JumpD = 1'($urandom);
    BranchD = 1'($urandom); ALUSrcD = 1'($urandom);
    ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom);
  endtask

  initial begin
    clear_inputs();
    // Reset: everything reads back as zero.
    reset = 1; RD1D = 32'h1234; RegWriteD = 1; tick();
    clear_inputs();
    // Plain load of a subtract.
    RD1D = 5; RD2D = 7; ALUSrcD = 0; ALUControlD = 3'b001; RegWriteD = 1; RdD = 3; tick();
    // Forward paths while holding the instruction.
    StallE = 1;
    ForwardAE = 2'b10; ALUResultM = 32'h20; tick();
    ForwardAE = 2'b01; ResultW = 32'h30; tick();
    ForwardAE = 2'b11; tick();
    ForwardAE = 2'b00;
    // Stall for three edges while D wiggles.
    for (int i = 0; i < 3; i++) begin randomize_d(); tick(); end
    // Flush beats stall.
    FlushE = 1; tick();
    clear_inputs();
    // Branch with negative offset, then zero flag both ways.
    BranchD = 1; PCD = 32'h100; ImmExtD = 32'hFFFF_FFF0; ZeroE = 1; tick();
    StallE = 1; ZeroE = 0; tick();
    StallE = 0; JumpD = 1; ZeroE = 0; tick();
    StallE = 1; ZeroE = 1; tick();
    // Target wraps.
    StallE = 0; JumpD = 0; BranchD = 0; PCD = 32'hFFFF_FFFC; ImmExtD = 32'h8; tick();
    // Immediate operand with forwarded store data.
    ALUSrcD = 1; ImmExtD = 32'h7FF; RD2D = 3; ForwardBE = 2'b10; ALUResultM = 9; tick();
    // Reset during a stall, then first unstalled load.
    StallE = 1; reset = 1; tick();
    reset = 0; StallE = 0; randomize_d(); tick();
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      randomize_d();
      StallE     = ($urandom_range(0, 3) == 0);
      FlushE     = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 31) == 0);
      ForwardAE  = 2'($urandom); ForwardBE = 2'($urandom);
      ALUResultM = $urandom; ResultW = $urandom; ZeroE = 1'($urandom);
      tick();
    end
    // Drain with a bound.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
